// File: rtl/dmem_arb_pkg.sv
// Shared types, sizing defaults and the address-window helper for the data-memory port arbiter.
package dmem_arb_pkg;

   typedef enum logic {
      NORMAL    = 1'b0,
      DMA_FORCE = 1'b1
   } arb_state_t;

   localparam int unsigned ARB_DEPTH        = 512;
   localparam int unsigned ARB_DMA_MAX_WAIT = 4;

   // Word 0 is reserved; anything at or beyond depth is outside the array.
   function automatic logic in_window(input logic [63:0] addr, input int unsigned depth);
      return (addr != 64'd0) && (addr < 64'(depth));
   endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Counts consecutive cycles a pending DMA request loses to the pipeline and forces
// one DMA cycle once the limit is reached.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   NORMAL    | pipeline has priority; count DMA losses while requested
//   DMA_FORCE | single cycle in which the DMA wins over the pipeline
module dmem_arb_starve_ctr
   import dmem_arb_pkg::*;
#(
   parameter int unsigned DMA_MAX_WAIT = ARB_DMA_MAX_WAIT
) (
   input  logic Clk,
   input  logic Reset,
   input  logic dma_req,
   input  logic pipe_req,
   output logic dma_force
);

   localparam int unsigned CNT_W = $clog2(DMA_MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DMA_MAX_WAIT);

   arb_state_t state, state_nxt;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state    <= NORMAL;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // Any DMA grant or an absent request restarts the count.
   always_comb begin
      state_nxt    = NORMAL;
      wait_cnt_nxt = '0;
      dma_force    = 1'b0;
      unique case (state)
         NORMAL: begin
            if (dma_req && pipe_req) begin
               wait_cnt_nxt = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);
               if (wait_cnt_nxt == CNT_MAX) state_nxt = DMA_FORCE;
            end
         end
         DMA_FORCE: begin
            dma_force = 1'b1;
         end
         default: begin
            state_nxt = NORMAL;
         end
      endcase
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the MEM stage and a DMA/debug loader,
// with pipeline priority, bounded DMA starvation and an address window check.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DEPTH        = ARB_DEPTH,
   parameter int unsigned DMA_MAX_WAIT = ARB_DMA_MAX_WAIT
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] ALU_Result_MEM,
   input  logic [DATA_W-1:0] Write_Data_MEM,
   input  logic              MemRead_MEM,
   input  logic              MemWrite_MEM,
   output logic [DATA_W-1:0] Read_Data_MEM,
   output logic              Stall_MEM,
   input  logic              Dma_Req,
   input  logic              Dma_We,
   input  logic [ADDR_W-1:0] Dma_Addr,
   input  logic [DATA_W-1:0] Dma_Wdata,
   output logic              Dma_Gnt,
   output logic [DATA_W-1:0] Dma_Rdata,
   output logic              Dma_Rvalid,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic [DATA_W-1:0] Mem_Wdata,
   output logic              Mem_We,
   input  logic [DATA_W-1:0] Mem_Rdata,
   output logic              Addr_Err
);

   logic pipe_req, pipe_grant, dma_grant, dma_force;
   logic issue_we, in_win;
   logic [ADDR_W-1:0] issue_addr;

   assign pipe_req = MemRead_MEM | MemWrite_MEM;

   dmem_arb_starve_ctr #(
      .DMA_MAX_WAIT(DMA_MAX_WAIT)
   ) u_starve_ctr (
      .Clk      (Clk),
      .Reset    (Reset),
      .dma_req  (Dma_Req),
      .pipe_req (pipe_req),
      .dma_force(dma_force)
   );

   assign pipe_grant = pipe_req & ~dma_force;
   assign dma_grant  = dma_force | (Dma_Req & ~pipe_req);
   assign Stall_MEM  = pipe_req & ~pipe_grant;
   assign Dma_Gnt    = dma_grant;

   always_comb begin
      issue_addr = '0;
      issue_we   = 1'b0;
      Mem_Wdata  = '0;
      if (pipe_grant) begin
         issue_addr = ALU_Result_MEM;
         issue_we   = MemWrite_MEM;
         Mem_Wdata  = Write_Data_MEM;
      end else if (dma_grant) begin
         issue_addr = Dma_Addr;
         issue_we   = Dma_We;
         Mem_Wdata  = Dma_Wdata;
      end
   end

   assign in_win   = in_window(64'(issue_addr), DEPTH);
   assign Mem_Addr = issue_addr;
   assign Mem_We   = issue_we & in_win;

   // A combined read+write request is treated as a store, so it returns no data.
   assign Read_Data_MEM = (pipe_grant && MemRead_MEM && !MemWrite_MEM && in_win) ? Mem_Rdata : '0;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Dma_Rdata  <= '0;
         Dma_Rvalid <= 1'b0;
         Addr_Err   <= 1'b0;
      end else begin
         Dma_Rvalid <= dma_grant & ~Dma_We;
         Addr_Err   <= (pipe_grant | dma_grant) & ~in_win;
         if (dma_grant && !Dma_We) Dma_Rdata <= in_win ? Mem_Rdata : '0;
      end
   end

endmodule
